// File: rtl/display_timings_480p_pkg.sv
// Shared 640x480@60 Hz timing constants for the video pipeline.
// Blanking sits at negative coordinates so the active area starts at (0,0).
package display_timings_480p_pkg;

    // Coordinate width able to hold -160..639 with margin.
    localparam int CORDW_480P  = 16;

    // Horizontal timing in pixels.
    localparam int H_RES_480P  = 640;
    localparam int H_FP_480P   = 16;
    localparam int H_SYNC_480P = 96;
    localparam int H_BP_480P   = 48;

    // Vertical timing in lines.
    localparam int V_RES_480P  = 480;
    localparam int V_FP_480P   = 10;
    localparam int V_SYNC_480P = 2;
    localparam int V_BP_480P   = 33;

    // Sync polarity: 0 means the pulse is driven low.
    localparam int H_POL_480P  = 0;
    localparam int V_POL_480P  = 0;

    // Total blanking length; the first coordinate of a line/frame is its negative.
    function automatic int blank_len(input int fp, input int sync, input int bp);
        return fp + sync + bp;
    endfunction

    // Derived signed markers for the default timing.
    localparam int H_STA_480P  = -blank_len(H_FP_480P, H_SYNC_480P, H_BP_480P); // -160
    localparam int HS_STA_480P = H_STA_480P + H_FP_480P;                        // -144
    localparam int HS_END_480P = HS_STA_480P + H_SYNC_480P;                     // -48
    localparam int HA_END_480P = H_RES_480P - 1;                                // 639
    localparam int V_STA_480P  = -blank_len(V_FP_480P, V_SYNC_480P, V_BP_480P); // -45
    localparam int VS_STA_480P = V_STA_480P + V_FP_480P;                        // -35
    localparam int VS_END_480P = VS_STA_480P + V_SYNC_480P;                     // -33
    localparam int VA_END_480P = V_RES_480P - 1;                                // 479

endpackage

// File: rtl/display_timings_480p.sv
// Raster timing generator: signed sx/sy counters plus zero-latency decode of
// hsync, vsync, data enable and the start-of-line / start-of-frame strobes.
module display_timings_480p
    import display_timings_480p_pkg::*;
#(
    parameter int CORDW  = CORDW_480P,
    parameter int H_RES  = H_RES_480P,
    parameter int V_RES  = V_RES_480P,
    parameter int H_FP   = H_FP_480P,
    parameter int H_SYNC = H_SYNC_480P,
    parameter int H_BP   = H_BP_480P,
    parameter int V_FP   = V_FP_480P,
    parameter int V_SYNC = V_SYNC_480P,
    parameter int V_BP   = V_BP_480P,
    parameter int H_POL  = H_POL_480P,
    parameter int V_POL  = V_POL_480P
) (
    input  logic                    clk_pix,
    input  logic                    rst,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line
);

    // Signed coordinate markers at counter width.
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-blank_len(H_FP, H_SYNC, H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-blank_len(H_FP, H_SYNC, H_BP) + H_FP);
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-blank_len(H_FP, H_SYNC, H_BP) + H_FP + H_SYNC);
    localparam logic signed [CORDW-1:0] HA_END = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-blank_len(V_FP, V_SYNC, V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-blank_len(V_FP, V_SYNC, V_BP) + V_FP);
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-blank_len(V_FP, V_SYNC, V_BP) + V_FP + V_SYNC);
    localparam logic signed [CORDW-1:0] VA_END = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] STEP   = CORDW'(32'sd1);

    // Asserted sync levels.
    localparam logic HS_ACT = (H_POL != 0) ? 1'b1 : 1'b0;
    localparam logic VS_ACT = (V_POL != 0) ? 1'b1 : 1'b0;

    logic signed [CORDW-1:0] sx_r;
    logic signed [CORDW-1:0] sy_r;
    logic signed [CORDW-1:0] sx_next_s;
    logic signed [CORDW-1:0] sy_next_s;
    logic                    hs_win_s;
    logic                    vs_win_s;

    // Next raster position: step across the line, wrap to blanking and advance the line at the end.
    always_comb begin
        sx_next_s = sx_r + STEP;
        sy_next_s = sy_r;
        if (sx_r == HA_END) begin
            sx_next_s = H_STA;
            if (sy_r == VA_END) begin
                sy_next_s = V_STA;
            end else begin
                sy_next_s = sy_r + STEP;
            end
        end else begin
            sy_next_s = sy_r;
        end
    end

    // Position counters; reset parks them at the start of vertical blanking.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sx_r <= H_STA;
            sy_r <= V_STA;
        end else begin
            sx_r <= sx_next_s;
            sy_r <= sy_next_s;
        end
    end

    // Decode sync pulses, active area and strobes straight from the current position.
    always_comb begin
        hs_win_s = (sx_r >= HS_STA) && (sx_r < HS_END);
        vs_win_s = (sy_r >= VS_STA) && (sy_r < VS_END);
        if (hs_win_s) begin
            hsync = HS_ACT;
        end else begin
            hsync = ~HS_ACT;
        end
        if (vs_win_s) begin
            vsync = VS_ACT;
        end else begin
            vsync = ~VS_ACT;
        end
        // Both coordinates non-negative means the sign bits are clear.
        de    = ~sx_r[CORDW-1] & ~sy_r[CORDW-1];
        line  = (sx_r == H_STA);
        frame = (sx_r == H_STA) && (sy_r == V_STA);
    end

    assign sx = sx_r;
    assign sy = sy_r;

endmodule

// File: tb/tb_display_timings_480p.sv
// Directed bench for display_timings_480p: default 480p timing, an
// inverted-polarity copy, and a tiny-timing copy for quick frame wraps.
module tb_display_timings_480p;

    logic clk_pix;
    logic rst;

    logic signed [15:0] sx,   sy,   sx_i, sy_i, sx_s, sy_s;
    logic hsync,   vsync,   de,   frame,   line;
    logic hsync_i, vsync_i, de_i, frame_i, line_i;
    logic hsync_s, vsync_s, de_s, frame_s, line_s;

    int tests  = 0;
    int failed = 0;

    display_timings_480p dut (
        .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy), .hsync(hsync),
        .vsync(vsync), .de(de), .frame(frame), .line(line)
    );

    display_timings_480p #(.H_POL(1), .V_POL(1)) dut_i (
        .clk_pix(clk_pix), .rst(rst), .sx(sx_i), .sy(sy_i), .hsync(hsync_i),
        .vsync(vsync_i), .de(de_i), .frame(frame_i), .line(line_i)
    );

    // Tiny raster: line = 15 clocks (H_STA -7, sync -5..-3, end 7),
    // frame = 8 lines (V_STA -4, sync -3..-2, end 3), sync active-high.
    display_timings_480p #(
        .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1), .V_POL(1)
    ) dut_s (
        .clk_pix(clk_pix), .rst(rst), .sx(sx_s), .sy(sy_s), .hsync(hsync_s),
        .vsync(vsync_s), .de(de_s), .frame(frame_s), .line(line_s)
    );

    initial clk_pix = 1'b0;
    always #20 clk_pix = ~clk_pix;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        if (obs !== expv) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    initial begin
        int ex_sx, ex_sy, ss_x, ss_y;
        logic e_hs, e_vs, e_de, e_ln, e_fr;
        logic s_hs, s_vs, s_de, s_ln, s_fr;
        int err_main, err_inv, err_small;
        int n_hs_lo, hs_first, hs_last, n_line, n_frame, n_de, first_de, n_vs_lo;
        int n_frame_s, n_hs_s, n_vs_s;

        err_main = 0; err_inv = 0; err_small = 0;
        n_hs_lo = 0; hs_first = 9999; hs_last = 9999; n_line = 0; n_frame = 0;
        n_de = 0; first_de = -1; n_vs_lo = 0;
        n_frame_s = 0; n_hs_s = 0; n_vs_s = 0;

        // Reset held for three edges, released just after the third.
        rst = 1'b1;
        repeat (3) @(posedge clk_pix);
        #1;
        rst = 1'b0;

        check("rst_sx",    sx,    -160);
        check("rst_sy",    sy,    -45);
        check("rst_frame", frame, 1);
        check("rst_line",  line,  1);
        check("rst_de",    de,    0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_small_sx", sx_s, -7);
        check("rst_small_sy", sy_s, -4);

        // Walk the raster up to the first row of the active area and beyond.
        for (int c = 0; c < 36960; c++) begin
            ex_sx = -160 + (c % 800);
            ex_sy = -45 + (c / 800);
            e_hs  = !((ex_sx >= -144) && (ex_sx < -48));
            e_vs  = !((ex_sy >= -35) && (ex_sy < -33));
            e_de  = (ex_sx >= 0) && (ex_sy >= 0);
            e_ln  = (ex_sx == -160);
            e_fr  = e_ln && (ex_sy == -45);

            if (sx != ex_sx || sy != ex_sy || hsync != e_hs || vsync != e_vs ||
                de != e_de || line != e_ln || frame != e_fr) begin
                if (err_main == 0)
                    $display("first main deviation at cycle %0d sx=%0d sy=%0d", c, sx, sy);
                err_main++;
            end
            if (sx_i != ex_sx || sy_i != ex_sy || hsync_i != !e_hs || vsync_i != !e_vs ||
                de_i != e_de || line_i != e_ln || frame_i != e_fr)
                err_inv++;

            ss_x = -7 + (c % 15);
            ss_y = -4 + ((c / 15) % 8);
            s_hs = (ss_x >= -5) && (ss_x < -2);
            s_vs = (ss_y >= -3) && (ss_y < -1);
            s_de = (ss_x >= 0) && (ss_y >= 0);
            s_ln = (ss_x == -7);
            s_fr = s_ln && (ss_y == -4);
            if (sx_s != ss_x || sy_s != ss_y || hsync_s != s_hs || vsync_s != s_vs ||
                de_s != s_de || line_s != s_ln || frame_s != s_fr)
                err_small++;

            if (c < 800 && hsync == 1'b0) begin
                n_hs_lo++;
                if (hs_first == 9999) hs_first = sx;
                hs_last = sx;
            end
            if (line)  n_line++;
            if (frame) n_frame++;
            if (de) begin
                n_de++;
                if (first_de < 0) first_de = c;
            end
            if (vsync == 1'b0) n_vs_lo++;
            if (frame_s) n_frame_s++;
            if (c < 15 && hsync_s)  n_hs_s++;
            if (c < 120 && vsync_s) n_vs_s++;

            if (c == 1) begin
                check("post_rst_sx",    sx,    -159);
                check("post_rst_frame", frame, 0);
                check("post_rst_line",  line,  0);
            end
            if (c == 799) check("line_end_sx", sx, 639);
            if (c == 800) begin
                check("wrap_sx",   sx,   -160);
                check("wrap_sy",   sy,   -44);
                check("wrap_line", line, 1);
            end
            if (c == 36160) begin
                check("de_rise_sx", sx, 0);
                check("de_rise_sy", sy, 0);
            end
            if (c == 119) check("small_sy_end",  sy_s, 3);
            if (c == 120) begin
                check("small_sy_wrap", sy_s,    -4);
                check("small_frame",   frame_s, 1);
            end
            step();
        end

        check("main_model_errs",  err_main,  0);
        check("inv_model_errs",   err_inv,   0);
        check("small_model_errs", err_small, 0);
        check("hsync_low_cycles", n_hs_lo,   96);
        check("hsync_first_sx",   hs_first,  -144);
        check("hsync_last_sx",    hs_last,   -49);
        check("line_pulses",      n_line,    47);
        check("frame_pulses",     n_frame,   1);
        check("de_first_cycle",   first_de,  36160);
        check("de_high_cycles",   n_de,      640);
        check("vsync_low_cycles", n_vs_lo,   1600);
        check("small_frames",     n_frame_s, 308);
        check("small_hsync_hi",   n_hs_s,    3);
        check("small_vsync_hi",   n_vs_s,    30);

        // Move to sx=100, sy=1 and reset in the middle of the line.
        repeat (100) step();
        check("pre_mid_sx", sx, 100);
        check("pre_mid_sy", sy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_sx",    sx,    -160);
        check("mid_rst_sy",    sy,    -45);
        check("mid_rst_frame", frame, 1);
        check("mid_rst_line",  line,  1);
        step();
        check("resume_sx",    sx,    -159);
        check("resume_frame", frame, 0);
        repeat (799) step();
        check("resume_wrap_sx",   sx,   -160);
        check("resume_wrap_sy",   sy,   -44);
        check("resume_wrap_line", line, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
